// File: rtl/add_accumulator_pkg.sv
// Shared constants and state encoding for the multi-operand add/sub accumulator.
// The adder width is fixed at 32 bits. LEN_W_DEFAULT sets the default operand-count width.
package add_accumulator_pkg;

    localparam int WIDTH         = 32;
    localparam int LEN_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/add_accumulator_csa.sv
// Team 32-bit carry-select adder: each block precomputes both carry-in cases and a mux picks one.
// OF is two's-complement overflow of X + Y + Cin, judged on the operands as presented.
module add_accumulator_csa
    import add_accumulator_pkg::*;
#(
    parameter int BLK = 8
) (
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             OF
);

    localparam int NBLK = WIDTH / BLK;

    logic [NBLK:0] blk_c;

    assign blk_c[0] = Cin;

    for (genvar b = 0; b < NBLK; b++) begin : g_blk
        logic [BLK:0] sum0;
        logic [BLK:0] sum1;

        assign sum0 = {1'b0, X[b*BLK +: BLK]} + {1'b0, Y[b*BLK +: BLK]};
        assign sum1 = {1'b0, X[b*BLK +: BLK]} + {1'b0, Y[b*BLK +: BLK]} + (BLK+1)'(1);

        assign S[b*BLK +: BLK] = blk_c[b] ? sum1[BLK-1:0] : sum0[BLK-1:0];
        assign blk_c[b+1]      = blk_c[b] ? sum1[BLK]     : sum0[BLK];
    end

    assign Cout = blk_c[NBLK];
    assign OF   = (X[WIDTH-1] == Y[WIDTH-1]) && (S[WIDTH-1] != X[WIDTH-1]);

endmodule

// File: rtl/add_accumulator.sv
// Feeds the shared adder one operand per accepted beat, keeps a running total and returns it.
// All outputs are registered or decoded from state, so no in_* input reaches out_* combinationally.
module add_accumulator
    import add_accumulator_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             busy
);

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic             ovf_q;
    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] len_q;

    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             of_d;
    logic [LEN_W-1:0] count_d;
    logic             last_beat;

    // Subtraction is acc + ~data + 1, so the adder sees the inverted operand with carry-in set.
    assign y_d = in_sub ? ~in_data : in_data;

    add_accumulator_csa u_adder (
        .X    (acc_q),
        .Y    (y_d),
        .Cin  (in_sub),
        .S    (sum_d),
        .Cout (cout_d),
        .OF   (of_d)
    );

    assign count_d   = count_q + LEN_W'(1);
    assign last_beat = (count_d == len_q);

    // NOTE: every register here takes <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= '0;
                        carry_q <= 1'b0;
                        ovf_q   <= 1'b0;
                        count_q <= '0;
                        len_q   <= len;
                        state_q <= (len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_q   <= sum_d;
                        carry_q <= cout_d;
                        ovf_q   <= ovf_q | of_d;
                        count_q <= count_d;
                        if (last_beat) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = acc_q;
    assign out_carry = carry_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_add_accumulator.sv
// Bench for add_accumulator. Random and directed jobs are checked each cycle against expectations
// built from an arithmetic model of the job. Hand-computed literals pin that model.
module tb_add_accumulator;
    import add_accumulator_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic        out_carry;
    logic        out_ovf;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected output values, updated by the stimulus at the points where they must change.
    logic        exp_in_ready  = 1'b0;
    logic        exp_out_valid = 1'b0;
    logic        exp_busy      = 1'b0;
    logic        exp_chk_data  = 1'b1;
    logic [31:0] exp_sum       = '0;
    logic        exp_carry     = 1'b0;
    logic        exp_ovf       = 1'b0;

    // Operands of the job under test, plus the DUT result captured when the job completes.
    logic [31:0] op_d [256];
    logic        op_s [256];
    logic [31:0] last_sum;
    logic        last_carry;
    logic        last_ovf;
    logic        last_valid;

    add_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    // Arithmetic reference: total mod 2^32, carry-out of the last beat, sticky signed overflow.
    function automatic void ref_model(input int n, output logic [31:0] s,
                                      output logic c, output logic o);
        logic [31:0] acc;
        logic [31:0] y;
        logic [32:0] r;
        acc = '0;
        c   = 1'b0;
        o   = 1'b0;
        for (int i = 0; i < n; i++) begin
            y   = op_s[i] ? ~op_d[i] : op_d[i];
            r   = {1'b0, acc} + {1'b0, y} + {32'd0, op_s[i]};
            o   = o | ((acc[31] == y[31]) && (r[31] != acc[31]));
            c   = r[32];
            acc = r[31:0];
        end
        s = acc;
    endfunction

    // Every cycle, on the falling edge, compare the outputs with the expected values.
    always @(negedge clk) begin
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_in_ready});
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_out_valid});
        check("busy", {31'd0, busy}, {31'd0, exp_busy});
        if (exp_chk_data) begin
            check("out_sum", out_sum, exp_sum);
            check("out_carry", {31'd0, out_carry}, {31'd0, exp_carry});
            check("out_ovf", {31'd0, out_ovf}, {31'd0, exp_ovf});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one job from IDLE through the result handshake.
    task automatic run_job(input int n, input int gap_pct, input int hold,
                           input bit poke_start, input bit junk_valid);
        logic [31:0] es;
        logic        ec;
        logic        eo;
        ref_model(n, es, ec, eo);

        start    = 1'b1;
        len      = 8'(n);
        in_valid = junk_valid;
        in_data  = 32'hDEAD_BEEF;
        in_sub   = 1'b0;
        tick();
        start         = 1'b0;
        in_valid      = 1'b0;
        exp_busy      = 1'b1;
        exp_in_ready  = (n != 0);
        exp_out_valid = (n == 0);
        exp_chk_data  = (n == 0);
        exp_sum       = '0;
        exp_carry     = 1'b0;
        exp_ovf       = 1'b0;
        if (n == 0) begin
            last_sum   = out_sum;
            last_carry = out_carry;
            last_ovf   = out_ovf;
            last_valid = out_valid;
        end

        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                in_sub   = 1'($urandom_range(1));
                tick();
            end
            in_valid = 1'b1;
            in_data  = op_d[i];
            in_sub   = op_s[i];
            tick();
            if (i == n - 1) begin
                exp_in_ready  = 1'b0;
                exp_out_valid = 1'b1;
                exp_chk_data  = 1'b1;
                exp_sum       = es;
                exp_carry     = ec;
                exp_ovf       = eo;
                last_sum      = out_sum;
                last_carry    = out_carry;
                last_ovf      = out_ovf;
                last_valid    = out_valid;
            end
        end

        // Junk on the operand port while the result waits must not disturb it.
        in_valid = 1'($urandom_range(1));
        in_data  = $urandom;
        in_sub   = 1'($urandom_range(1));
        for (int h = 0; h < hold; h++) begin
            start = poke_start && (h == 0);
            len   = 8'd3;
            tick();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready     = 1'b0;
        in_valid      = 1'b0;
        exp_out_valid = 1'b0;
        exp_busy      = 1'b0;
        exp_chk_data  = 1'b0;
    endtask

    task automatic set_ops4(input logic [31:0] d0, input bit s0, input logic [31:0] d1, input bit s1,
                            input logic [31:0] d2, input bit s2, input logic [31:0] d3, input bit s3);
        op_d[0] = d0; op_s[0] = s0;
        op_d[1] = d1; op_s[1] = s1;
        op_d[2] = d2; op_s[2] = s2;
        op_d[3] = d3; op_s[3] = s3;
    endtask

    task automatic check_result(input string tag, input logic [31:0] s, input bit c, input bit o);
        check({tag, "_valid"}, {31'd0, last_valid}, 32'd1);
        check({tag, "_sum"}, last_sum, s);
        check({tag, "_carry"}, {31'd0, last_carry}, {31'd0, c});
        check({tag, "_ovf"}, {31'd0, last_ovf}, {31'd0, o});
    endtask

    initial begin
        #12 rst_n = 1'b1;
        tick();

        set_ops4(32'd1, 0, 32'd2, 0, 32'd3, 0, 32'd0, 0);
        run_job(3, 0, 0, 0, 0);
        check_result("basic", 32'd6, 0, 0);

        set_ops4(32'h7FFF_FFFF, 0, 32'h1, 0, 32'd0, 0, 32'd0, 0);
        run_job(2, 0, 1, 0, 1);
        check_result("sovf", 32'h8000_0000, 0, 1);

        set_ops4(32'hFFFF_FFFF, 0, 32'h1, 0, 32'd0, 0, 32'd0, 0);
        run_job(2, 0, 0, 0, 0);
        check_result("wrap", 32'h0, 1, 0);

        set_ops4(32'd5, 0, 32'd7, 1, 32'd0, 0, 32'd0, 0);
        run_job(2, 0, 2, 1, 0);
        check_result("borrow", 32'hFFFF_FFFE, 0, 0);

        set_ops4(32'h7FFF_FFFF, 0, 32'h1, 0, 32'h1, 1, 32'd0, 0);
        run_job(3, 0, 0, 0, 0);
        check_result("sticky", 32'h7FFF_FFFF, 1, 1);

        run_job(0, 0, 5, 1, 1);
        check_result("zero", 32'h0, 0, 0);

        // Abort a 4-beat job after two beats with an asynchronous reset.
        set_ops4(32'd100, 0, 32'd200, 0, 32'd300, 0, 32'd400, 0);
        start = 1'b1;
        len   = 8'd4;
        tick();
        start = 1'b0;
        exp_busy     = 1'b1;
        exp_in_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = op_d[i];
            in_sub   = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        exp_in_ready  = 1'b0;
        exp_out_valid = 1'b0;
        exp_busy      = 1'b0;
        exp_chk_data  = 1'b1;
        exp_sum       = '0;
        exp_carry     = 1'b0;
        exp_ovf       = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_sum", out_sum, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        tick();

        set_ops4(32'd10, 0, 32'd20, 0, 32'd30, 0, 32'd40, 0);
        run_job(4, 60, 1, 0, 0);
        check_result("gaps", 32'd100, 0, 0);

        for (int i = 0; i < 255; i++) begin
            op_d[i] = 32'd1;
            op_s[i] = 1'b0;
        end
        run_job(255, 0, 0, 0, 0);
        check_result("maxlen", 32'd255, 0, 0);

        for (int j = 0; j < 60; j++) begin
            int n;
            n = (j % 15 == 14) ? 0 : int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(3))
                    0:       op_d[i] = 32'h7FFF_FFFF;
                    1:       op_d[i] = 32'h8000_0000;
                    2:       op_d[i] = 32'($urandom_range(0, 3));
                    default: op_d[i] = $urandom;
                endcase
                op_s[i] = 1'($urandom_range(1));
            end
            run_job(n, 30, int'($urandom_range(0, 3)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
